// File: rtl/seg7_pkg.sv
// seg7_pkg: shared scan state type and default timing for the seven-segment display path.
package seg7_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   localparam int TICKS_PER_DIGIT = 100000;
   localparam int BLANK_TICKS     = 1000;

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed digit scanner with per-slot blanking and frame-aligned updates.
module seg7_scan #(
   parameter int NUM_DIGITS      = 8,
   parameter int TICKS_PER_DIGIT = seg7_pkg::TICKS_PER_DIGIT,
   parameter int BLANK_TICKS     = seg7_pkg::BLANK_TICKS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     dots,
   input  logic [NUM_DIGITS-1:0]     digit_en,
   input  logic                      load,
   output logic [3:0]                nibble,
   output logic                      dot,
   output logic [NUM_DIGITS-1:0]     anode,
   output logic                      frame_done
);
   import seg7_pkg::*;

   localparam int CW = $clog2(TICKS_PER_DIGIT);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] LAST_TICK  = CW'(TICKS_PER_DIGIT - 1);
   localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_TICKS - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

   scan_state_t               r_state;
   logic [CW-1:0]             r_cnt;
   logic [IW-1:0]             r_idx;
   logic [4*NUM_DIGITS-1:0]   r_pv, r_av;
   logic [NUM_DIGITS-1:0]     r_pd, r_ad, r_pe, r_ae;
   logic                      r_pflag;
   logic [3:0]                r_nibble;
   logic                      r_dot;
   logic [NUM_DIGITS-1:0]     r_anode;
   logic                      r_fd;

   scan_state_t               w_state_n;
   logic                      w_slot_end, w_bound, w_take, w_fd_n;
   logic [CW-1:0]             w_cnt_n;
   logic [IW-1:0]             w_idx_n;
   logic [4*NUM_DIGITS-1:0]   w_av_n;
   logic [NUM_DIGITS-1:0]     w_ad_n, w_ae_n, w_anode_n;

   // Outputs are registered from next-state values so they line up with the slot they describe.
   always_comb begin
      w_slot_end = r_cnt == LAST_TICK;
      w_bound    = w_slot_end && r_idx == LAST_IDX;
      w_cnt_n    = w_slot_end ? '0 : r_cnt + 1'b1;
      w_idx_n    = w_slot_end ? (r_idx == LAST_IDX ? '0 : r_idx + 1'b1) : r_idx;
      w_state_n  = w_slot_end ? BLANK : (r_state == BLANK && r_cnt == LAST_BLANK) ? DRIVE : r_state;
      w_take     = w_bound && (load || r_pflag);
      w_av_n     = w_take ? (load ? value : r_pv) : r_av;
      w_ad_n     = w_take ? (load ? dots : r_pd) : r_ad;
      w_ae_n     = w_take ? (load ? digit_en : r_pe) : r_ae;
      w_fd_n     = w_cnt_n == LAST_TICK && w_idx_n == LAST_IDX;
      w_anode_n  = '1;
      if (w_state_n == DRIVE && w_ae_n[w_idx_n])
         w_anode_n[w_idx_n] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= BLANK;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_pv     <= '0;
         r_pd     <= '0;
         r_pe     <= '0;
         r_pflag  <= 1'b0;
         r_av     <= '0;
         r_ad     <= '0;
         r_ae     <= '0;
         r_nibble <= '0;
         r_dot    <= 1'b0;
         r_anode  <= '1;
         r_fd     <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_cnt    <= w_cnt_n;
         r_idx    <= w_idx_n;
         r_av     <= w_av_n;
         r_ad     <= w_ad_n;
         r_ae     <= w_ae_n;
         r_nibble <= w_av_n[{w_idx_n, 2'b00} +: 4];
         r_dot    <= w_ad_n[w_idx_n];
         r_anode  <= w_anode_n;
         r_fd     <= w_fd_n;
         // A load on the boundary cycle goes straight to active, so nothing stays pending.
         if (load) begin
            r_pv    <= value;
            r_pd    <= dots;
            r_pe    <= digit_en;
            r_pflag <= !w_bound;
         end else if (w_bound)
            r_pflag <= 1'b0;
      end
   end

   assign nibble     = r_nibble;
   assign dot        = r_dot;
   assign anode      = r_anode;
   assign frame_done = r_fd;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: random and directed scan checks against a cycle-time arithmetic model.
module tb_seg7_scan;
   localparam int N = 4;
   localparam int T = 8;
   localparam int B = 2;
   localparam int F = N * T;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   value = '0;
   logic [3:0]    dots = '0;
   logic [3:0]    digit_en = '0;
   logic          load = 1'b0;
   logic [3:0]    nibble;
   logic          dot;
   logic [3:0]    anode;
   logic          frame_done;

   int            errors = 0;
   int            checks = 0;

   int            t = 0;
   bit            valid = 0;
   logic [15:0]   m_av = '0, m_pv = '0;
   logic [3:0]    m_ad = '0, m_pd = '0, m_ae = '0, m_pe = '0;
   bit            m_pf = 0;

   seg7_scan #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .BLANK_TICKS(B)) dut (
      .clk(clk), .rst(rst), .value(value), .dots(dots), .digit_en(digit_en), .load(load),
      .nibble(nibble), .dot(dot), .anode(anode), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   task automatic cyc(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
      int dig, pos;
      logic [3:0] exp_an;
      rst = r; load = ld; value = v; dots = d; digit_en = e;
      @(negedge clk);
      if (valid) begin
         dig = (t / T) % N;
         pos = t % T;
         exp_an = 4'hF;
         if (pos >= B && m_ae[dig]) exp_an = ~(4'b1 << dig);
         check("anode", 32'(anode), 32'(exp_an));
         check("nibble", 32'(nibble), 32'((m_av >> (4 * dig)) & 16'hF));
         check("dot", 32'(dot), 32'(m_ad[dig]));
         check("frame_done", 32'(frame_done), 32'(t % F == F - 1));
         check("one_low", 32'($countones(~anode) <= 1), 32'd1);
      end
      @(posedge clk);
      if (r) begin
         m_av = '0; m_ad = '0; m_ae = '0; m_pf = 0; t = 0; valid = 1;
      end else begin
         if (ld) begin m_pv = v; m_pd = d; m_pe = e; m_pf = 1; end
         if (t % F == F - 1 && m_pf) begin
            m_av = m_pv; m_ad = m_pd; m_ae = m_pe; m_pf = 0;
         end
         t++;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
   endtask

   task automatic wait_pos(input int p);
      for (int i = 0; i < F && t % F != p; i++) idle(1);
      check("wait_pos", 32'(t % F), 32'(p));
   endtask

   initial begin
      cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      idle(40);
      check("dark_after_reset", 32'(anode), 32'hF);
      cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      idle(5);
      cyc(1'b0, 1'b1, 16'h1234, 4'b0001, 4'b1111);
      idle(2 * F);
      cyc(1'b0, 1'b1, 16'($urandom), 4'($urandom), 4'b0101);
      idle(2 * F);
      wait_pos(3);
      cyc(1'b0, 1'b1, 16'hAAAA, 4'hF, 4'hF);
      idle(4);
      cyc(1'b0, 1'b1, 16'hBBBB, 4'h0, 4'hF);
      idle(2 * F);
      wait_pos(F - 1);
      cyc(1'b0, 1'b1, 16'hCCCC, 4'h5, 4'hF);
      check("c_active", 32'(m_av), 32'hCCCC);
      idle(F + 3);
      cyc(1'b0, 1'b1, 16'h1234, 4'h0, 4'hF);
      wait_pos(10);
      cyc(1'b0, 1'b1, 16'h5678, 4'hF, 4'hF);
      wait_pos(2 * T + 4);
      cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      check("rst_anode", 32'(anode), 32'hF);
      check("rst_nibble", 32'(nibble), 32'h0);
      idle(2 * F);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0)
            cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
         else
            cyc(1'b0, $urandom_range(0, 11) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
